// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate encodings, ordered-set type codes and the PAD symbol.
// Used by mainLTSSM and by the Tx ordered-set sequencer.
package ltssm_pkg;

  localparam logic [3:0] ST_DETECT_QUIET            = 4'd0;
  localparam logic [3:0] ST_DETECT_ACTIVE           = 4'd1;
  localparam logic [3:0] ST_POLLING_ACTIVE          = 4'd2;
  localparam logic [3:0] ST_POLLING_CONFIGURATION   = 4'd3;
  localparam logic [3:0] ST_CONFIG_LINKWIDTH_START  = 4'd4;
  localparam logic [3:0] ST_CONFIG_LINKWIDTH_ACCEPT = 4'd5;
  localparam logic [3:0] ST_CONFIG_LANENUM_WAIT     = 4'd6;
  localparam logic [3:0] ST_CONFIG_LANENUM_ACCEPT   = 4'd7;
  localparam logic [3:0] ST_CONFIG_COMPLETE         = 4'd8;
  localparam logic [3:0] ST_CONFIG_IDLE             = 4'd9;
  localparam logic [3:0] ST_L0                      = 4'd10;

  typedef enum logic [1:0] {
    OS_TS1  = 2'd0,
    OS_TS2  = 2'd1,
    OS_IDLE = 2'd2,
    OS_RSVD = 2'd3
  } os_type_e;

  localparam logic [7:0] PAD_SYMBOL = 8'hF7;

  // Substates that transmit ordered sets are also the ones guarded by the timeout.
  function automatic logic is_timed_substate(input logic [3:0] s);
    return (s >= ST_POLLING_ACTIVE) && (s <= ST_CONFIG_IDLE);
  endfunction

endpackage

// File: rtl/tx_ltssm_os_sequencer_if.sv
// Ordered-set request bus between the Tx sequencer (master) and the OS generator (slave).
interface tx_ltssm_os_sequencer_if;

  logic       osValid;
  logic [1:0] osType;
  logic [7:0] osLinkNumber;
  logic [7:0] osLaneNumber;
  logic       osReady;

  modport master (
    output osValid,
    output osType,
    output osLinkNumber,
    output osLaneNumber,
    input  osReady
  );

  modport slave (
    input  osValid,
    input  osType,
    input  osLinkNumber,
    input  osLaneNumber,
    output osReady
  );

endinterface

// File: rtl/ltssm_timeout_timer.sv
// Saturating cycle timer shared by detectQuiet dwell and the polling/configuration timeout.
// hit flags the cycle in which the count reaches limit-1.
module ltssm_timeout_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + ONE;
    end
  end

  // Compare the incoming value so the registered finish lands on the same edge the count does.
  assign hit = !clear && (count_d == (limit - ONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tx_ltssm_os_sequencer.sv
// Tx-side substate controller: drives the ordered-set generator for the current substate,
// counts accepted ordered sets, runs the dwell/timeout timer and reports finishTx/gotoTx.
module tx_ltssm_os_sequencer
  import ltssm_pkg::*;
#(
  parameter int DEVICETYPE     = 0,
  parameter int QUIET_CYCLES   = 12000,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int MIN_TS1_COUNT  = 1024,
  parameter int POST_COUNT     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               substateTx,
  input  logic                     rxConditionMet,
  input  logic                     detectDone,
  input  logic [4:0]               detectedLanes,
  input  logic [7:0]               linkNumberIn,
  input  logic [7:0]               laneNumberIn,
  tx_ltssm_os_sequencer_if.master  os,
  output logic                     detectReq,
  output logic                     finishTx,
  output logic [3:0]               gotoTx
);

  localparam int MAX_LIMIT = (QUIET_CYCLES > TIMEOUT_CYCLES) ? QUIET_CYCLES : TIMEOUT_CYCLES;
  localparam int TIMER_W   = $clog2(MAX_LIMIT + 1);

  localparam logic [TIMER_W-1:0] QUIET_LIMIT   = TIMER_W'(QUIET_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [10:0]        MIN_TS1       = 11'(MIN_TS1_COUNT);
  localparam logic [10:0]        SENT_MAX      = 11'h7FF;
  localparam logic [4:0]         POST_TARGET   = 5'(POST_COUNT);
  localparam logic [4:0]         POST_MAX      = 5'h1F;

  logic [3:0]  prev_substate_q, prev_substate_d;
  logic        run_q, run_d;
  logic [10:0] sent_count_q, sent_count_d;
  logic [4:0]  post_count_q, post_count_d;
  logic        rx_seen_q, rx_seen_d;
  logic        finish_q, finish_d;
  logic [3:0]  goto_q, goto_d;
  logic        detect_req_q, detect_req_d;

  logic               entry;
  logic               handshake;
  logic               count_en;
  logic               link_qual;
  logic               os_valid;
  os_type_e           os_type;
  logic [7:0]         os_link;
  logic [7:0]         os_lane;
  logic               success;
  logic [3:0]         success_goto;
  logic               timer_hit;
  logic [TIMER_W-1:0] timer_limit;

  assign entry       = (substateTx != prev_substate_q);
  assign handshake   = os_valid && os.osReady;
  assign timer_limit = (substateTx == ST_DETECT_QUIET) ? QUIET_LIMIT : TIMEOUT_LIMIT;

  ltssm_timeout_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (entry),
    .limit (timer_limit),
    .hit   (timer_hit)
  );

  // Content follows the live substate so no request with stale fields survives a change;
  // run_q keeps the bus quiet until the first edge after reset.
  always_comb begin
    os_valid  = 1'b0;
    os_type   = OS_TS1;
    os_link   = PAD_SYMBOL;
    os_lane   = PAD_SYMBOL;
    link_qual = (DEVICETYPE == 0) || rxConditionMet || (rx_seen_q && !entry);
    if (run_q) begin
      case (substateTx)
        ST_POLLING_ACTIVE: begin
          os_valid = 1'b1;
        end
        ST_POLLING_CONFIGURATION: begin
          os_valid = 1'b1;
          os_type  = OS_TS2;
        end
        ST_CONFIG_LINKWIDTH_START: begin
          os_valid = 1'b1;
          if (link_qual) begin
            os_link = linkNumberIn;
          end
        end
        ST_CONFIG_LINKWIDTH_ACCEPT, ST_CONFIG_LANENUM_WAIT, ST_CONFIG_LANENUM_ACCEPT: begin
          os_valid = 1'b1;
          os_link  = linkNumberIn;
          os_lane  = laneNumberIn;
        end
        ST_CONFIG_COMPLETE: begin
          os_valid = 1'b1;
          os_type  = OS_TS2;
          os_link  = linkNumberIn;
          os_lane  = laneNumberIn;
        end
        ST_CONFIG_IDLE: begin
          os_valid = 1'b1;
          os_type  = OS_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  assign os.osValid      = os_valid;
  assign os.osType       = os_type;
  assign os.osLinkNumber = os_link;
  assign os.osLaneNumber = os_lane;

  // Counters restart on entry and freeze once this substate has finished.
  always_comb begin
    sent_count_d    = sent_count_q;
    post_count_d    = post_count_q;
    rx_seen_d       = rx_seen_q | rxConditionMet;
    prev_substate_d = substateTx;
    run_d           = 1'b1;
    count_en        = handshake && !entry && !finish_q;
    if (entry) begin
      sent_count_d = '0;
      post_count_d = '0;
      rx_seen_d    = 1'b0;
    end else if (count_en) begin
      if (sent_count_q != SENT_MAX) begin
        sent_count_d = sent_count_q + 11'd1;
      end
      if (rx_seen_q && (post_count_q != POST_MAX)) begin
        post_count_d = post_count_q + 5'd1;
      end
    end
  end

  // A successful exit takes priority over a timeout landing in the same cycle.
  always_comb begin
    success      = 1'b0;
    success_goto = ST_DETECT_QUIET;
    case (substateTx)
      ST_DETECT_QUIET: begin
        success      = timer_hit;
        success_goto = ST_DETECT_ACTIVE;
      end
      ST_DETECT_ACTIVE: begin
        success      = detectDone;
        success_goto = (detectedLanes != 5'd0) ? ST_POLLING_ACTIVE : ST_DETECT_QUIET;
      end
      ST_POLLING_ACTIVE: begin
        success      = (sent_count_d >= MIN_TS1) && rxConditionMet;
        success_goto = ST_POLLING_CONFIGURATION;
      end
      ST_POLLING_CONFIGURATION: begin
        success      = (post_count_d == POST_TARGET);
        success_goto = ST_CONFIG_LINKWIDTH_START;
      end
      ST_CONFIG_COMPLETE: begin
        success      = (post_count_d == POST_TARGET);
        success_goto = ST_CONFIG_IDLE;
      end
      ST_CONFIG_IDLE: begin
        success      = (post_count_d == POST_TARGET);
        success_goto = ST_L0;
      end
      default: begin
      end
    endcase

    finish_d     = finish_q;
    goto_d       = goto_q;
    detect_req_d = entry && (substateTx == ST_DETECT_ACTIVE);
    if (entry) begin
      finish_d = 1'b0;
    end else if (!finish_q) begin
      if (success) begin
        finish_d = 1'b1;
        goto_d   = success_goto;
      end else if (is_timed_substate(substateTx) && timer_hit) begin
        finish_d = 1'b1;
        goto_d   = ST_DETECT_QUIET;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_substate_q <= 4'hF;
      run_q           <= 1'b0;
      sent_count_q    <= '0;
      post_count_q    <= '0;
      rx_seen_q       <= 1'b0;
      finish_q        <= 1'b0;
      goto_q          <= ST_DETECT_QUIET;
      detect_req_q    <= 1'b0;
    end else begin
      prev_substate_q <= prev_substate_d;
      run_q           <= run_d;
      sent_count_q    <= sent_count_d;
      post_count_q    <= post_count_d;
      rx_seen_q       <= rx_seen_d;
      finish_q        <= finish_d;
      goto_q          <= goto_d;
      detect_req_q    <= detect_req_d;
    end
  end

  // The stale finish from the previous substate is hidden during the entry cycle itself.
  assign finishTx  = finish_q && !entry;
  assign gotoTx    = goto_q;
  assign detectReq = detect_req_q;

endmodule
